// File: rtl/quartz_spi_pkg.sv
// Shared SPI framing definitions: deframer states, checksum seed and default payload limit.
package quartz_spi_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_PAY,
    S_SUM,
    S_HOLD,
    S_DRAIN
  } deframer_state_e;

  localparam logic [7:0] SUM_SEED_DEF = 8'hCC;
  localparam int unsigned MAX_LEN_DEF = 32;

endpackage

// File: rtl/spi_pkt_buf.sv
// Packet payload buffer: MAX_LEN x 8 RAM, one write port, one registered read port.
module spi_pkt_buf
  import quartz_spi_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_LEN_DEF,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/spi_cmd_deframer.sv
// Extracts one length-prefixed, XOR-checksummed command packet per SPI chip-select frame.
module spi_cmd_deframer
  import quartz_spi_pkg::*;
#(
  parameter int unsigned MAX_LEN  = MAX_LEN_DEF,
  parameter logic [7:0]  SUM_SEED = SUM_SEED_DEF,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_frame_end,
  output logic             pkt_valid,
  output logic [7:0]       pkt_len,
  input  logic [AW-1:0]    pkt_rd_addr,
  output logic [7:0]       pkt_rd_data,
  input  logic             pkt_ack,
  output logic             evt_pkt,
  output logic [CNT_W-1:0] err_len_cnt,
  output logic [CNT_W-1:0] err_sum_cnt,
  output logic [CNT_W-1:0] err_ovr_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  deframer_state_e state_q, state_d;
  logic [7:0] len_q, len_d, sum_q, sum_d, idx_q, idx_d;
  logic wr_en, accept, inc_len, inc_sum, inc_ovr;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    accept  = 1'b0;
    inc_len = 1'b0;
    inc_sum = 1'b0;
    inc_ovr = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        S_LEN: begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            inc_len = 1'b1;
            state_d = S_DRAIN;
          end else begin
            len_d   = rx_data;
            sum_d   = SUM_SEED ^ rx_data;
            idx_d   = '0;
            state_d = S_PAY;
          end
        end
        S_PAY: begin
          wr_en = 1'b1;
          sum_d = sum_q ^ rx_data;
          idx_d = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = S_SUM;
        end
        S_SUM: begin
          if (rx_data == sum_q) begin
            accept  = 1'b1;
            state_d = S_HOLD;
          end else begin
            inc_sum = 1'b1;
            state_d = S_DRAIN;
          end
        end
        S_HOLD:  inc_ovr = 1'b1;
        S_DRAIN: ;
        default: state_d = S_LEN;
      endcase
    end

    // frame_end is applied to the state reached after this cycle's byte, if any
    if (rx_frame_end) begin
      case (state_d)
        S_PAY, S_SUM: begin
          inc_len = 1'b1;
          state_d = S_LEN;
        end
        S_DRAIN: state_d = S_LEN;
        default: ;
      endcase
    end

    if (pkt_ack && state_q == S_HOLD) state_d = S_LEN;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= S_LEN;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      pkt_valid   <= 1'b0;
      pkt_len     <= '0;
      evt_pkt     <= 1'b0;
      err_len_cnt <= '0;
      err_sum_cnt <= '0;
      err_ovr_cnt <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      pkt_valid <= (state_d == S_HOLD);
      evt_pkt   <= accept;
      if (accept) pkt_len <= len_q;
      if (inc_len && err_len_cnt != '1) err_len_cnt <= err_len_cnt + 1'b1;
      if (inc_sum && err_sum_cnt != '1) err_sum_cnt <= err_sum_cnt + 1'b1;
      if (inc_ovr && err_ovr_cnt != '1) err_ovr_cnt <= err_ovr_cnt + 1'b1;
    end
  end

  spi_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (idx_q[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (pkt_rd_addr),
    .rd_data (pkt_rd_data)
  );

endmodule
